// File: rtl/axis_ad5791_pkg.sv
// Shared constants and types for the AD5791 SPI frame receiver.
// Field positions describe the AD5791 input shift register layout.
package axis_ad5791_pkg;

  localparam int AD5791_FRAME_BITS = 24;
  localparam int AD5791_RW_BIT     = 23;
  localparam int AD5791_ADDR_MSB   = 22;
  localparam int AD5791_ADDR_LSB   = 20;
  localparam int AD5791_DATA_MSB   = 19;
  localparam int AD5791_DATA_LSB   = 0;

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } rx_state_e;

endpackage

// File: rtl/ad5791_sync_edge.sv
// N-stage synchroniser for one asynchronous SPI wire, plus a history flop
// for edge detection. STAGES must be at least 2.
module ad5791_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              hist_reg;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (srst) sync_reg[gi] <= 1'b0;
          else      sync_reg[gi] <= d;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (srst) sync_reg[gi] <= 1'b0;
          else      sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) hist_reg <= 1'b0;
    else      hist_reg <= sync_reg[STAGES-1];
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = sync_reg[STAGES-1] & ~hist_reg;
  assign fall  = ~sync_reg[STAGES-1] & hist_reg;

endmodule

// File: rtl/axis_ad5791_spi_rx.sv
// Oversampling SPI slave for the AD5791 3-wire link: deserialises each
// SYNC-framed word MSB first and presents it on an AXI-Stream master.
module axis_ad5791_spi_rx
  import axis_ad5791_pkg::*;
#(
  parameter int FRAME_BITS  = AD5791_FRAME_BITS,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_areset,
  input  logic                  dac_sclk,
  input  logic                  dac_sdi,
  input  logic                  dac_syncn,
  output logic [FRAME_BITS-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  frame_err,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  frame_count
);

  localparam int CW = $clog2(FRAME_BITS + 2);

  logic sclk_level_unused, sclk_rise_unused, sclk_fall;
  logic sdi_level, sdi_rise_unused, sdi_fall_unused;
  logic syncn_level, syncn_rise, syncn_fall;

  ad5791_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk(m_axis_aclk), .srst(m_axis_areset), .d(dac_sclk),
    .level(sclk_level_unused), .rise(sclk_rise_unused), .fall(sclk_fall)
  );
  ad5791_sync_edge #(.STAGES(SYNC_STAGES)) u_sdi (
    .clk(m_axis_aclk), .srst(m_axis_areset), .d(dac_sdi),
    .level(sdi_level), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
  );
  ad5791_sync_edge #(.STAGES(SYNC_STAGES)) u_syncn (
    .clk(m_axis_aclk), .srst(m_axis_areset), .d(dac_syncn),
    .level(syncn_level), .rise(syncn_rise), .fall(syncn_fall)
  );

  rx_state_e             state_reg, state_next;
  logic [FRAME_BITS-1:0] shift_reg, shift_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic                  do_load, do_err, do_ovf;
  logic                  out_free;

  assign out_free = ~m_axis_tvalid | m_axis_tready;

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) state_reg <= WAIT_HIGH;
    else               state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT_HIGH: if (syncn_level) state_next = IDLE;
      IDLE:      if (syncn_fall)  state_next = SHIFT;
      SHIFT:     if (syncn_rise)  state_next = IDLE;
      default:                    state_next = WAIT_HIGH;
    endcase
  end

  // A bit landing in the same cycle as the closing sync edge is counted
  // before the frame is judged, so evaluation looks at cnt_next.
  always_comb begin
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    do_load    = 1'b0;
    do_err     = 1'b0;
    do_ovf     = 1'b0;
    case (state_reg)
      IDLE: if (syncn_fall) cnt_next = '0;
      SHIFT: begin
        if (sclk_fall) begin
          if (cnt_reg < CW'(FRAME_BITS))
            shift_next = {shift_reg[FRAME_BITS-2:0], sdi_level};
          if (cnt_reg != CW'(FRAME_BITS + 1))
            cnt_next = cnt_reg + 1'b1;
        end
        if (syncn_rise) begin
          if (cnt_next != CW'(FRAME_BITS)) do_err  = 1'b1;
          else if (out_free)               do_load = 1'b1;
          else                             do_ovf  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      shift_reg     <= '0;
      cnt_reg       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      frame_err     <= 1'b0;
      overflow      <= 1'b0;
      frame_count   <= '0;
    end else begin
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
      frame_err <= do_err;
      overflow  <= do_ovf;
      if (do_load) begin
        m_axis_tdata  <= shift_next;
        m_axis_tvalid <= 1'b1;
        frame_count   <= frame_count + 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
